// File: rtl/cosx_pkg.sv
// Shared types and default widths for the CosX request sequencer.
package cosx_pkg;

  localparam int X_W_DEF = 10;
  localparam int Y_W_DEF = 8;
  localparam int R_W_DEF = 10;
  localparam int LAT_W   = 16;

  typedef struct packed {
    logic [X_W_DEF-1:0] x;
    logic [Y_W_DEF-1:0] y;
    logic [R_W_DEF-1:0] expected;
  } cosx_vec_t;

  typedef enum logic [3:0] {
    IDLE,
    FETCH,
    LOAD,
    WAIT_IDLE,
    START,
    WAIT_ACK,
    WAIT_DONE,
    CHECK,
    DONE
  } seq_state_t;

endpackage

// File: rtl/cosx_rise_detect.sv
// Rising-edge detector for the accelerator ready level; history resets high so a
// ready that is already asserted out of reset does not produce an edge.
module cosx_rise_detect (
  input  logic clk,
  input  logic rst,
  input  logic level_i,
  output logic rise_o
);

  logic level_q;

  always_ff @(posedge clk) begin
    if (!rst) level_q <= 1'b1;
    else      level_q <= level_i;
  end

  assign rise_o = level_i & ~level_q;

endmodule

// File: rtl/cosx_request_sequencer.sv
// Walks a {x, y, expected} vector ROM through the CosX start/ready handshake and
// scores each result. Define COSX_LATENCY_STATS_EN to build start-to-ready latency tracking.
module cosx_request_sequencer
  import cosx_pkg::*;
#(
  parameter int NUM_VEC      = 10,
  parameter int X_W          = X_W_DEF,
  parameter int Y_W          = Y_W_DEF,
  parameter int R_W          = R_W_DEF,
  parameter int START_CYCLES = 2,
  parameter int TIMEOUT      = 255
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   go,
  output logic [9:0]             rom_addr,
  input  logic [X_W+Y_W+R_W-1:0] rom_data,
  output logic [X_W-1:0]         acc_x,
  output logic [Y_W-1:0]         acc_y,
  output logic                   acc_start,
  input  logic [R_W-1:0]         acc_result,
  input  logic                   acc_ready,
  output logic                   busy,
  output logic                   done,
  output logic [9:0]             pass_cnt,
  output logic [9:0]             err_cnt,
  output logic                   timeout,
  output logic [LAT_W-1:0]       max_lat
);

  localparam int TMR_W = 16;

  seq_state_t       state_q, state_d;
  logic [TMR_W-1:0] tmr_q, tmr_d;
  logic [9:0]       addr_q, addr_d;
  logic [9:0]       pass_q, pass_d;
  logic [9:0]       err_q, err_d;
  logic [X_W-1:0]   x_q, x_d;
  logic [Y_W-1:0]   y_q, y_d;
  logic [R_W-1:0]   exp_q, exp_d;
  logic [R_W-1:0]   res_q, res_d;
  logic             tout_q, tout_d;
  logic             rdy_rise;
  logic             tmr_tc;

  cosx_rise_detect u_rise (
    .clk     (clk),
    .rst     (rst),
    .level_i (acc_ready),
    .rise_o  (rdy_rise)
  );

  assign tmr_tc = (tmr_q == '0);

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    addr_d  = addr_q;
    pass_d  = pass_q;
    err_d   = err_q;
    x_d     = x_q;
    y_d     = y_q;
    exp_d   = exp_q;
    res_d   = res_q;
    tout_d  = tout_q;
    unique case (state_q)
      IDLE: begin
        if (go) begin
          pass_d  = '0;
          err_d   = '0;
          tout_d  = 1'b0;
          addr_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: state_d = LOAD;
      LOAD: begin
        x_d     = rom_data[X_W+Y_W+R_W-1 -: X_W];
        y_d     = rom_data[Y_W+R_W-1 -: Y_W];
        exp_d   = rom_data[R_W-1:0];
        state_d = WAIT_IDLE;
      end
      WAIT_IDLE: begin
        if (acc_ready) state_d = START;
        else if (tmr_tc) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      START: if (tmr_tc) state_d = WAIT_ACK;
      WAIT_ACK: begin
        if (!acc_ready) state_d = WAIT_DONE;
        else if (tmr_tc) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      WAIT_DONE: begin
        if (rdy_rise) begin
          res_d   = acc_result;
          state_d = CHECK;
        end else if (tmr_tc) begin
          tout_d  = 1'b1;
          state_d = DONE;
        end
      end
      CHECK: begin
        if (res_q == exp_q) begin
          if (pass_q != 10'h3FF) pass_d = pass_q + 10'd1;
        end else begin
          if (err_q != 10'h3FF) err_d = err_q + 10'd1;
        end
        if (addr_q == 10'(NUM_VEC - 1)) state_d = DONE;
        else begin
          addr_d  = addr_q + 10'd1;
          state_d = FETCH;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // One down-counter serves both the START hold and the wait-state timeouts.
    if (state_d != state_q)
      tmr_d = (state_d == START) ? TMR_W'(START_CYCLES - 1) : TMR_W'(TIMEOUT);
    else if (!tmr_tc)
      tmr_d = tmr_q - 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      addr_q  <= '0;
      pass_q  <= '0;
      err_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      exp_q   <= '0;
      res_q   <= '0;
      tout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      addr_q  <= addr_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      x_q     <= x_d;
      y_q     <= y_d;
      exp_q   <= exp_d;
      res_q   <= res_d;
      tout_q  <= tout_d;
    end
  end

`ifdef COSX_LATENCY_STATS_EN
  logic [LAT_W-1:0] lat_q, lat_d;
  logic [LAT_W-1:0] max_q, max_d;

  // lat_q reads 0 in the first START cycle, so in CHECK it holds the inclusive count.
  always_comb begin
    lat_d = lat_q;
    max_d = max_q;
    if (state_q == IDLE && go) max_d = '0;
    if (state_d == START && state_q != START)
      lat_d = '0;
    else if (state_q inside {START, WAIT_ACK, WAIT_DONE} && lat_q != '1)
      lat_d = lat_q + 1'b1;
    if (state_q == CHECK && lat_q > max_q) max_d = lat_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lat_q <= '0;
      max_q <= '0;
    end else begin
      lat_q <= lat_d;
      max_q <= max_d;
    end
  end

  assign max_lat = max_q;
`else
  assign max_lat = '0;
`endif

  assign rom_addr  = addr_q;
  assign acc_x     = x_q;
  assign acc_y     = y_q;
  assign acc_start = (state_q == START);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = (state_q == DONE);
  assign pass_cnt  = pass_q;
  assign err_cnt   = err_q;
  assign timeout   = tout_q;

endmodule

// File: tb/tb_cosx_request_sequencer.sv
// Directed bench: registered vector ROM plus a behavioural CosX accelerator model.
module tb_cosx_request_sequencer;
  import cosx_pkg::*;

  localparam int NV = 10;
`ifdef COSX_LATENCY_STATS_EN
  localparam int EXP_LAT = 21;
`else
  localparam int EXP_LAT = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go  = 1'b0;
  logic [9:0]  rom_addr;
  logic [27:0] rom_data = '0;
  logic [9:0]  acc_x;
  logic [7:0]  acc_y;
  logic        acc_start;
  logic [9:0]  acc_result = '0;
  logic        acc_ready  = 1'b1;
  logic        busy, done, timeout;
  logic [9:0]  pass_cnt, err_cnt;
  logic [15:0] max_lat;

  int n_chk  = 0;
  int n_fail = 0;

  cosx_vec_t rom [NV];

  logic       hang = 1'b0, corrupt = 1'b0, force_low = 1'b0;
  int         m_cnt = 0;
  logic [9:0] lx = '0;
  logic [7:0] ly = '0;

  always #5 clk = ~clk;

  cosx_request_sequencer #(
    .NUM_VEC(NV), .X_W(10), .Y_W(8), .R_W(10), .START_CYCLES(2), .TIMEOUT(255)
  ) dut (
    .clk(clk), .rst(rst), .go(go), .rom_addr(rom_addr), .rom_data(rom_data),
    .acc_x(acc_x), .acc_y(acc_y), .acc_start(acc_start), .acc_result(acc_result),
    .acc_ready(acc_ready), .busy(busy), .done(done), .pass_cnt(pass_cnt),
    .err_cnt(err_cnt), .timeout(timeout), .max_lat(max_lat)
  );

  function automatic logic [9:0] golden(logic [9:0] x, logic [7:0] y);
    return (x ^ {y, 2'b01}) + 10'd7;
  endfunction

  always @(posedge clk)
    rom_data <= (int'(rom_addr) < NV) ? rom[rom_addr] : '0;

  // Accelerator: ready drops after start is seen, rises 20 cycles after that start.
  always @(posedge clk) begin
    if (force_low) acc_ready <= 1'b0;
    else if (m_cnt != 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        acc_ready  <= 1'b1;
        acc_result <= golden(lx, ly) ^ ((corrupt && lx == rom[3].x) ? 10'd1 : 10'd0);
      end
    end else if (acc_start && acc_ready) begin
      acc_ready <= 1'b0;
      lx        <= acc_x;
      ly        <= acc_y;
      m_cnt     <= hang ? 0 : 19;
    end else if (!acc_ready && !hang) acc_ready <= 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic pulse_go();
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
  endtask

  task automatic step_to(inout int cyc, input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic wait_done(inout int cyc);
    while (!done && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1);
  end

  initial begin
    int  cyc;
    bit  saw_done;
    for (int i = 0; i < NV; i++) begin
      rom[i].x        = 10'(37 * i + 5);
      rom[i].y        = 8'(11 * i + 3);
      rom[i].expected = golden(rom[i].x, rom[i].y);
    end

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_addr", rom_addr, 0);
    chk("rst_start", acc_start, 0);
    chk("rst_pass", pass_cnt, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_max_lat", max_lat, 0);
    rst = 1'b1;
    @(negedge clk);

    // Normal run: 25 cycles per vector, done one cycle after the last CHECK
    pulse_go(); cyc = 1;
    chk("run1_busy", busy, 1);
    wait_done(cyc);
    chk("run1_done", done, 1);
    chk("run1_cycles", cyc, 251);
    chk("run1_busy_at_done", busy, 0);
    chk("run1_pass", pass_cnt, 10);
    chk("run1_err", err_cnt, 0);
    chk("run1_timeout", timeout, 0);
    chk("run1_max_lat", max_lat, EXP_LAT);
    chk("run1_last_addr", rom_addr, 9);
    @(negedge clk);
    chk("run1_done_pulse_len", done, 0);

    // Corrupted result on vector 3
    corrupt = 1'b1;
    pulse_go(); cyc = 1;
    while (!(acc_start && rom_addr == 10'd3) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    chk("v3_start_seen", acc_start, 1);
    chk("v3_acc_x", acc_x, rom[3].x);
    chk("v3_acc_y", acc_y, rom[3].y);
    wait_done(cyc);
    chk("run2_done", done, 1);
    chk("run2_pass", pass_cnt, 9);
    chk("run2_err", err_cnt, 1);
    chk("run2_max_lat", max_lat, EXP_LAT);
    corrupt = 1'b0;
    @(negedge clk);

    // Accelerator never raises ready: abort 256 cycles into WAIT_DONE
    hang = 1'b1;
    pulse_go(); cyc = 1;
    wait_done(cyc);
    chk("tmo_done", done, 1);
    chk("tmo_cycles", cyc, 263);
    chk("tmo_flag", timeout, 1);
    chk("tmo_start", acc_start, 0);
    chk("tmo_busy", busy, 0);
    chk("tmo_pass", pass_cnt, 0);
    chk("tmo_err", err_cnt, 0);
    chk("tmo_max_lat", max_lat, 0);
    hang = 1'b0;
    repeat (4) @(negedge clk);
    chk("tmo_sticky", timeout, 1);

    // Reset during WAIT_DONE of vector 5
    pulse_go(); cyc = 1;
    step_to(cyc, 140);
    chk("mid_addr", rom_addr, 5);
    chk("mid_pass", pass_cnt, 5);
    rst = 1'b0;
    @(negedge clk);
    chk("mrst_addr", rom_addr, 0);
    chk("mrst_x", acc_x, 0);
    chk("mrst_y", acc_y, 0);
    chk("mrst_start", acc_start, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_done", done, 0);
    chk("mrst_pass", pass_cnt, 0);
    chk("mrst_timeout", timeout, 0);
    chk("mrst_max_lat", max_lat, 0);
    chk("mrst_state", 32'(dut.state_q), 32'(IDLE));
    rst = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) saw_done = 1'b1;
    end
    chk("mrst_no_done", saw_done, 0);
    pulse_go(); cyc = 1;
    chk("restart_addr", rom_addr, 0);
    chk("restart_busy", busy, 1);
    wait_done(cyc);
    chk("restart_cycles", cyc, 251);
    chk("restart_pass", pass_cnt, 10);
    @(negedge clk);

    // Ready low at go, second go while busy is ignored
    force_low = 1'b1;
    repeat (2) @(negedge clk);
    pulse_go(); cyc = 1;
    step_to(cyc, 5);
    go = 1'b1;
    @(negedge clk); cyc++;
    go = 1'b0;
    step_to(cyc, 30);
    chk("wi_busy", busy, 1);
    chk("wi_start", acc_start, 0);
    chk("wi_addr", rom_addr, 0);
    force_low = 1'b0;
    wait_done(cyc);
    chk("wi_done", done, 1);
    chk("wi_cycles", cyc, 279);
    chk("wi_pass", pass_cnt, 10);
    chk("wi_err", err_cnt, 0);
    chk("wi_timeout", timeout, 0);
    chk("wi_max_lat", max_lat, EXP_LAT);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/cosx_request_sequencer.md
Name: cosx_request_sequencer

Overview:
- Initiator side of the CosX start/ready handshake; drives the CosX accelerator's x, y and start inputs, and consumes its result and ready outputs.
- Walks a vector ROM with entries {x, y, expected}. For each entry it issues one request, waits for completion, captures the result, compares it with the expected value and counts pass/fail.
- Used as an on-chip self-test front end for the accelerator and as the synthesizable driver in system benches.

Parameters:
- NUM_VEC, 10, number of ROM entries walked per run (1..1023)
- X_W, 10, accelerator x operand width
- Y_W, 8, accelerator y operand width
- R_W, 10, accelerator result width
- START_CYCLES, 2, cycles start is held high per request (>=1)
- TIMEOUT, 255, max cycles allowed in any wait state before abort

Ports:
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-low reset
- go  in  1  one-cycle pulse that begins a run; ignored unless idle
- rom_addr  out  10  vector ROM address
- rom_data  in  X_W+Y_W+R_W  {x, y, expected}; valid one cycle after rom_addr changes (registered ROM)
- acc_x  out  X_W  operand x to accelerator
- acc_y  out  Y_W  operand y to accelerator
- acc_start  out  1  request strobe
- acc_result  in  R_W  accelerator result
- acc_ready  in  1  accelerator ready/done level
- busy  out  1  run in progress
- done  out  1  one-cycle pulse at end of run (normal or aborted)
- pass_cnt  out  10  vectors that matched
- err_cnt  out  10  vectors that mismatched
- timeout  out  1  sticky; run aborted by timeout
- max_lat  out  16  largest start-to-ready latency seen (feature-gated)

Behaviour:
- Reset (rst==0 at posedge):
  - FSM goes to IDLE.
  - All outputs become 0: rom_addr, acc_x, acc_y, acc_start, busy, done, pass_cnt, err_cnt, timeout, max_lat.
  - Reset mid-run aborts immediately with no done pulse.
- States: IDLE, FETCH, LOAD, WAIT_IDLE, START, WAIT_ACK, WAIT_DONE, CHECK, DONE.
- IDLE: on go=1:
  - clear pass_cnt, err_cnt, timeout and max_lat;
  - set rom_addr=0 and busy=1;
  - go to FETCH.
- FETCH: one cycle for ROM latency, then LOAD.
- LOAD: register acc_x, acc_y and the expected value from rom_data; go to WAIT_IDLE. acc_x and acc_y hold stable until the next LOAD.
- WAIT_IDLE: wait for acc_ready==1, then go to START.
- START: acc_start=1 for exactly START_CYCLES cycles; the latency counter is cleared on the first cycle. Then go to WAIT_ACK.
- WAIT_ACK: wait for acc_ready==0. If acc_ready is already 0 on entry, leave after one cycle.
- WAIT_DONE: wait for acc_ready 0->1. acc_result is sampled in the same cycle acc_ready is first seen high. Then go to CHECK.
- Latency measurement:
  - Counts cycles from the first START cycle to the cycle ready is seen high, inclusive.
  - Saturates at 16'hFFFF.
- CHECK: one cycle.
  - Increment pass_cnt if the sampled result equals the expected value, else increment err_cnt (both saturate at 1023).
  - If rom_addr==NUM_VEC-1, go to DONE; else increment rom_addr and go to FETCH.
- DONE: done=1 and busy=0 for one cycle, then IDLE. Counters hold until the next go.
- Timeout:
  - A per-state wait counter runs in WAIT_IDLE, WAIT_ACK and WAIT_DONE and resets on every state change.
  - When it exceeds TIMEOUT: set timeout=1, force acc_start=0, go to DONE.
- Simultaneous events:
  - go while busy is ignored.
  - acc_ready rising during START is ignored; an edge is only recognised in WAIT_DONE.
- Invariant: pass_cnt + err_cnt == NUM_VEC after a normal run.

Optional Feature:
- COSX_LATENCY_STATS_EN defined: the latency counter is built and max_lat is updated in CHECK when the new latency exceeds it.
- Not defined: no latency counter; max_lat is tied to 0. The rest of the behaviour is identical.

Decomposition:
- Package cosx_pkg holds:
  - the X_W, Y_W and R_W defaults as localparams;
  - typedef cosx_vec_t, a packed struct {x, y, expected};
  - typedef seq_state_t, an enum of the FSM states;
  - constant LAT_W=16.
- One sub-module, cosx_rise_detect: registers acc_ready and outputs a rising-edge pulse. It resets to 1, so a ready that is high out of reset is not counted as an edge.

Test Plan:
- Behavioural accelerator model (ready drops 1 cycle after start, rises 20 cycles later, correct result), NUM_VEC=10, go -> done after the 10th CHECK; pass_cnt=10, err_cnt=0, max_lat=21 with the feature on.
- Model corrupts the result on vector 3 -> err_cnt=1, pass_cnt=9; acc_x/acc_y for vector 3 equal the ROM fields.
- Model never raises ready after start, TIMEOUT=255 -> timeout=1, done pulse ~256 cycles into WAIT_DONE, acc_start=0.
- rst=0 asserted during WAIT_DONE of vector 5 -> next cycle all outputs 0, state IDLE, no done pulse; a new go restarts at rom_addr=0.
- go pulsed again while busy, and acc_ready held 0 at the moment of go -> second go ignored; sequencer waits in WAIT_IDLE until ready=1 then proceeds normally.
- Build without COSX_LATENCY_STATS_EN -> max_lat stays 0, counters match the first scenario.
